// File: rtl/sntc_ldpc_qc_encoder_seq_if.sv
`default_nettype none
// ============================================================================
// sntc_ldpc_qc_encoder_seq_if : info-in / codeword-out streams of the QC encoder
// Revision 1.0
// ============================================================================
interface sntc_ldpc_qc_encoder_seq_if #(
   parameter int Z = 8
);
   logic [Z-1:0] in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [Z-1:0] out_data;
   logic         out_valid;
   logic         out_last;
   logic         out_is_par;
   logic         out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_is_par
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_is_par
   );
endinterface
`default_nettype wire

// File: rtl/sntc_ldpc_qc_encoder_seq.sv
`default_nettype none
// ============================================================================
// sntc_ldpc_qc_encoder_seq : streaming QC-LDPC systematic encoder (info pass-through + MB parity)
// Revision 1.0
// ============================================================================
module sntc_ldpc_qc_encoder_seq #(
   parameter int Z  = 8,
   parameter int KB = 4,
   parameter int MB = 3,
   parameter int SW = $clog2(Z) + 1,
   parameter logic [KB*MB*SW-1:0] SHIFT = '0
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  clr,
   sntc_ldpc_qc_encoder_seq_if.slave  s,
   output logic                       frame_err,
   output logic [15:0]                frames_done
);
   localparam int c_IBW = (KB > 1) ? $clog2(KB) : 1;
   localparam int c_PBW = (MB > 1) ? $clog2(MB) : 1;
   localparam logic [c_IBW-1:0] c_IB_LAST = c_IBW'(KB - 1);
   localparam logic [c_PBW-1:0] c_PB_LAST = c_PBW'(MB - 1);

   typedef enum logic [0:0] {ST_ACC = 1'b0, ST_PAR = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [c_IBW-1:0]   ib_q, ib_d;
   logic [c_PBW-1:0]   pb_q, pb_d;
   logic [Z-1:0]       acc_q [MB];
   logic [Z-1:0]       acc_d [MB];
   logic [Z-1:0]       out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               out_is_par_q, out_is_par_d;
   logic               frame_err_q, frame_err_d;
   logic [15:0]        frames_done_q, frames_done_d;
   logic               w_out_free;
   logic               w_in_ready;
   logic [SW-1:0]      w_ent;

   // rot(x,s)[k] = x[(k+s) mod Z]
   function automatic logic [Z-1:0] rot(input logic [Z-1:0] x, input logic [SW-2:0] sh);
      logic [Z-1:0] r;
      int           m;
      m = int'(sh) % Z;
      for (int k = 0; k < Z; k++) begin
         r[k] = x[(k + m) % Z];
      end
      return r;
   endfunction

   assign w_out_free = !out_valid_q || s.out_ready;
   assign w_in_ready = !rst && (state_q == ST_ACC) && w_out_free;

   always_comb begin
      state_d       = state_q;
      ib_d          = ib_q;
      pb_d          = pb_q;
      acc_d         = acc_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      out_is_par_d  = out_is_par_q;
      frame_err_d   = 1'b0;
      frames_done_d = frames_done_q;
      w_ent         = '0;

      if (out_valid_q && s.out_ready) begin
         out_valid_d  = 1'b0;
         out_last_d   = 1'b0;
         out_is_par_d = 1'b0;
      end

      if (clr) begin
         state_d      = ST_ACC;
         ib_d         = '0;
         pb_d         = '0;
         out_valid_d  = 1'b0;
         out_last_d   = 1'b0;
         out_is_par_d = 1'b0;
         for (int j = 0; j < MB; j++) acc_d[j] = '0;
      end else if (state_q == ST_ACC) begin
         if (s.in_valid && w_in_ready) begin
            out_data_d   = s.in_data;
            out_valid_d  = 1'b1;
            out_is_par_d = 1'b0;
            out_last_d   = 1'b0;
            if (s.in_last == (ib_q == c_IB_LAST)) begin
               for (int j = 0; j < MB; j++) begin
                  w_ent = SHIFT[(int'(ib_q) * MB + j) * SW +: SW];
                  if (!w_ent[SW-1]) acc_d[j] = acc_d[j] ^ rot(s.in_data, w_ent[SW-2:0]);
               end
               if (ib_q == c_IB_LAST) begin
                  state_d = ST_PAR;
                  ib_d    = '0;
                  pb_d    = '0;
               end else begin
                  ib_d = ib_q + c_IBW'(1);
               end
            end else begin
               // Misplaced in_last: the beat still flows out, the partial codeword is dropped.
               frame_err_d = 1'b1;
               ib_d        = '0;
               for (int j = 0; j < MB; j++) acc_d[j] = '0;
            end
         end
      end else if (w_out_free) begin
         out_data_d   = acc_q[pb_q];
         out_valid_d  = 1'b1;
         out_is_par_d = 1'b1;
         out_last_d   = (pb_q == c_PB_LAST);
         if (pb_q == c_PB_LAST) begin
            state_d       = ST_ACC;
            pb_d          = '0;
            frames_done_d = frames_done_q + 16'd1;
            for (int j = 0; j < MB; j++) acc_d[j] = '0;
         end else begin
            pb_d = pb_q + c_PBW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_ACC;
         ib_q          <= '0;
         pb_q          <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_is_par_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         frames_done_q <= '0;
         for (int j = 0; j < MB; j++) acc_q[j] <= '0;
      end else begin
         state_q       <= state_d;
         ib_q          <= ib_d;
         pb_q          <= pb_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         out_is_par_q  <= out_is_par_d;
         frame_err_q   <= frame_err_d;
         frames_done_q <= frames_done_d;
         acc_q         <= acc_d;
      end
   end

   assign s.in_ready   = w_in_ready;
   assign s.out_data   = out_data_q;
   assign s.out_valid  = out_valid_q;
   assign s.out_last   = out_last_q;
   assign s.out_is_par = out_is_par_q;
   assign frame_err    = frame_err_q;
   assign frames_done  = frames_done_q;
endmodule
`default_nettype wire

// File: tb/tb_sntc_ldpc_qc_encoder_seq.sv
`default_nettype none
// ============================================================================
// tb_sntc_ldpc_qc_encoder_seq : scoreboard bench, directed Z=4 config plus random default config
// Revision 1.0
// ============================================================================
module tb_sntc_ldpc_qc_encoder_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr_a = 1'b0;
   logic clr_b = 1'b0;
   logic        ferr_a, ferr_b;
   logic [15:0] fd_a, fd_b;

   always #5 clk = ~clk;

   sntc_ldpc_qc_encoder_seq_if #(.Z(4)) ifa ();
   sntc_ldpc_qc_encoder_seq_if #(.Z(8)) ifb ();

   // (0,0)=0, (0,1)=1, (1,0)=null, (1,1)=3
   sntc_ldpc_qc_encoder_seq #(.Z(4), .KB(2), .MB(2), .SHIFT(12'b011_100_001_000)) u_dut_a (
      .clk(clk), .rst(rst), .clr(clr_a), .s(ifa), .frame_err(ferr_a), .frames_done(fd_a)
   );

   sntc_ldpc_qc_encoder_seq u_dut_b (
      .clk(clk), .rst(rst), .clr(clr_b), .s(ifb), .frame_err(ferr_b), .frames_done(fd_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   typedef struct packed {
      logic [7:0] d;
      logic       par;
      logic       last;
   } beat_t;

   function automatic beat_t mk(input logic [7:0] d, input logic par, input logic last);
      beat_t b;
      b.d = d; b.par = par; b.last = last;
      return b;
   endfunction

   beat_t qa[$];
   beat_t qb[$];
   int    mode_a = 0;
   int    err_a = 0, err_b = 0;
   int    run_a = 0, maxrun_a = 0;
   logic  stall_a = 1'b0;
   logic [3:0] hold_a = '0;

   always @(posedge clk) begin
      #1;
      case (mode_a)
         0:       ifa.out_ready = 1'b1;
         1:       ifa.out_ready = ~ifa.out_ready;
         default: ifa.out_ready = 1'b0;
      endcase
      ifb.out_ready = ($urandom_range(3) != 0);
   end

   always @(negedge clk) begin
      beat_t e;
      if (!rst) begin
         if (stall_a) begin
            chk("a_hold_data", 32'(ifa.out_data), 32'(hold_a));
            chk("a_hold_valid", 32'(ifa.out_valid), 32'd1);
         end
         if (ifa.out_valid && !ifa.out_ready) chk("a_stall_in_ready", 32'(ifa.in_ready), 32'd0);
         stall_a = ifa.out_valid && !ifa.out_ready && !clr_a;
         hold_a  = ifa.out_data;
         if (ferr_a) err_a++;
         run_a = ifa.out_valid ? run_a + 1 : 0;
         if (run_a > maxrun_a) maxrun_a = run_a;
         if (ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 32'd1, 32'd0);
            else begin
               e = qa.pop_front();
               chk("a_data", 32'(ifa.out_data), 32'(e.d));
               chk("a_is_par", 32'(ifa.out_is_par), 32'(e.par));
               chk("a_last", 32'(ifa.out_last), 32'(e.last));
            end
         end
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (!rst) begin
         if (ferr_b) err_b++;
         if (ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", 32'd1, 32'd0);
            else begin
               e = qb.pop_front();
               chk("b_data", 32'(ifb.out_data), 32'(e.d));
               chk("b_is_par", 32'(ifb.out_is_par), 32'(e.par));
               chk("b_last", 32'(ifb.out_last), 32'(e.last));
            end
         end
      end
   end

   task automatic a_send(input logic [3:0] d, input logic last, input logic push);
      ifa.in_data  = d;
      ifa.in_last  = last;
      ifa.in_valid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (ifa.in_ready) break;
         if (n > 100) begin chk("a_send_timeout", 32'd0, 32'd1); break; end
      end
      if (push) qa.push_back(mk({4'b0, d}, 1'b0, 1'b0));
      @(posedge clk); #2;
      ifa.in_valid = 1'b0;
      ifa.in_last  = 1'b0;
   endtask

   task automatic a_frame(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] p0, input logic [3:0] p1);
      a_send(d0, 1'b0, 1'b1);
      a_send(d1, 1'b1, 1'b1);
      qa.push_back(mk({4'b0, p0}, 1'b1, 1'b0));
      qa.push_back(mk({4'b0, p1}, 1'b1, 1'b1));
   endtask

   task automatic a_drain();
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (qa.size() == 0 && !ifa.out_valid) break;
         if (n > 300) begin chk("a_drain_timeout", 32'd0, 32'd1); break; end
      end
      @(posedge clk); #2;
   endtask

   task automatic b_send(input logic [7:0] d, input logic last);
      ifb.in_data  = d;
      ifb.in_last  = last;
      ifb.in_valid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (ifb.in_ready) break;
         if (n > 200) begin chk("b_send_timeout", 32'd0, 32'd1); break; end
      end
      qb.push_back(mk(d, 1'b0, 1'b0));
      @(posedge clk); #2;
      ifb.in_valid = 1'b0;
      ifb.in_last  = 1'b0;
   endtask

   task automatic b_drain();
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (qb.size() == 0 && !ifb.out_valid) break;
         if (n > 300) begin chk("b_drain_timeout", 32'd0, 32'd1); break; end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] info [4];
      logic [7:0] par;
      ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
      ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
      chk("rst_out_valid_a", 32'(ifa.out_valid), 32'd0);
      chk("rst_frames_done_a", 32'(fd_a), 32'd0);
      chk("rst_frames_done_b", 32'(fd_b), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready_a", 32'(ifa.in_ready), 32'd1);
      chk("post_rst_in_ready_b", 32'(ifb.in_ready), 32'd1);
      @(posedge clk); #2;

      // Basic frame, continuous output
      mode_a = 0; maxrun_a = 0;
      a_frame(4'b0001, 4'b0010, 4'b0001, 4'b1100);
      a_drain();
      chk("t1_frames_done", 32'(fd_a), 32'd1);
      chk("t1_valid_run", 32'(maxrun_a), 32'd4);

      // Output back-pressure toggling
      mode_a = 1;
      a_frame(4'b0001, 4'b0010, 4'b0001, 4'b1100);
      a_drain();
      chk("t2_frames_done", 32'(fd_a), 32'd2);

      // Back-to-back frames
      mode_a = 0;
      a_frame(4'b1000, 4'b0000, 4'b1000, 4'b0100);
      a_frame(4'b0100, 4'b0001, 4'b0100, 4'b0000);
      a_drain();
      chk("t3_frames_done", 32'(fd_a), 32'd4);

      // Early in_last
      err_a = 0;
      a_send(4'b0101, 1'b1, 1'b1);
      a_drain();
      chk("t4_frame_err_early", 32'(err_a), 32'd1);
      chk("t4_frames_done", 32'(fd_a), 32'd4);
      a_frame(4'b0001, 4'b0010, 4'b0001, 4'b1100);
      a_drain();
      chk("t4_recover_frames_done", 32'(fd_a), 32'd5);

      // Missing in_last on the final block
      a_send(4'b0011, 1'b0, 1'b1);
      a_send(4'b0110, 1'b0, 1'b1);
      a_drain();
      chk("t5_frame_err_missing", 32'(err_a), 32'd2);
      a_frame(4'b1000, 4'b0000, 4'b1000, 4'b0100);
      a_drain();
      chk("t5_frames_done", 32'(fd_a), 32'd6);

      // Synchronous clear after the first info beat
      mode_a = 2;
      a_send(4'b0001, 1'b0, 1'b0);
      chk("t6_pre_clr_valid", 32'(ifa.out_valid), 32'd1);
      clr_a = 1'b1;
      @(posedge clk); #2;
      clr_a = 1'b0;
      chk("t6_post_clr_valid", 32'(ifa.out_valid), 32'd0);
      mode_a = 0;
      a_frame(4'b0001, 4'b0010, 4'b0001, 4'b1100);
      a_drain();
      chk("t6_frames_done", 32'(fd_a), 32'd7);

      // Default config, random frames: every parity block is the XOR of the info blocks
      for (int f = 0; f < 1000; f++) begin
         par = '0;
         for (int i = 0; i < 4; i++) begin
            info[i] = 8'($urandom);
            par     = par ^ info[i];
         end
         for (int i = 0; i < 3; i++) b_send(info[i], 1'b0);
         b_send(info[3], 1'b1);
         qb.push_back(mk(par, 1'b1, 1'b0));
         qb.push_back(mk(par, 1'b1, 1'b0));
         qb.push_back(mk(par, 1'b1, 1'b1));
      end
      b_drain();
      chk("b_frames_done", 32'(fd_b), 32'd1000);
      chk("b_no_frame_err", 32'(err_b), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sntc_ldpc_qc_encoder_seq.md
# sntc_ldpc_qc_encoder_seq

Streaming, parametrised quasi-cyclic (QC) LDPC systematic encoder. It is the sequential successor to the fixed-size combinational encoder wrapper. Lift size, info/parity block counts and the circulant shift table are all parameters. Info enters as Z-bit blocks over a valid/ready handshake, is passed through, and is followed on the same output stream by MB parity blocks. It sits between the segment buffer and the syndrome checker / rate matcher.

## Interface
- Z, 8: lift size, bits per block; Z ≥ 2.
- KB, 4: info blocks per codeword; KB ≥ 1.
- MB, 3: parity blocks per codeword; MB ≥ 1.
- SW, $clog2(Z)+1: width of one shift-table entry.
- SHIFT, '0: packed KB*MB*SW table.
  - Entry (i,j) sits at [(i*MB+j)*SW +: SW] and couples info block i into parity block j.
  - MSB=1 means a null (all-zero) circulant.
  - Otherwise the low bits give shift s, 0..Z-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; abort the frame.
- in_data  in  Z  info block.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final info block of a frame.
- in_ready  out  1  block can accept a beat.
- out_data  out  Z  codeword block, info then parity.
- out_valid  out  1  out_data valid.
- out_last  out  1  marks the final parity block.
- out_is_par  out  1  the current out beat is parity.
- frame_err  out  1  one-cycle pulse: in_last was misplaced.
- frames_done  out  16  count of completed codewords; wraps.

## Operation
- Rotation: rot(x,s)[k] = x[(k+s) mod Z].
- Accumulators: MB registers acc[j], each Z bits.
- Two-state FSM: ACC (take info) and PAR (emit parity).
- ACC state:
  - in_ready = !out_valid || out_ready.
  - On input handshake (in_valid && in_ready) with block counter ib:
    - out_data ← in_data, out_valid ← 1, out_is_par ← 0.
    - acc[j] ← acc[j] ^ rot(in_data, s(ib,j)) for every non-null j; null entries leave acc[j] unchanged.
  - ib increments per accepted beat.
  - If ib==KB-1: the beat must carry in_last=1. Then go to PAR with pb=0 and ib=0.
  - If in_last=1 with ib<KB-1, or in_last=0 with ib==KB-1:
    - Beat still passes to output.
    - frame_err pulses 1 cycle.
    - All acc cleared, ib←0, stay in ACC, no parity emitted.
- PAR state:
  - in_ready=0.
  - When !out_valid || out_ready: out_data ← acc[pb], out_valid ← 1, out_is_par ← 1, out_last ← (pb==MB-1), then pb increments.
  - When the last parity beat is loaded: clear all acc, increment frames_done (mod 2^16), return to ACC.
- Output register:
  - Holds its beat while out_valid && !out_ready.
  - Clears out_valid when handshaken and no new beat is loaded.
- clr (sync, priority over handshakes): FSM→ACC, ib=pb=0, acc=0, out_valid=0, out_last=0, out_is_par=0. frames_done is kept.
- rst: all state and outputs 0 (in_ready=0 during reset, 1 the first cycle after), FSM=ACC, frames_done=0.

## Timing
- Info beat accepted in cycle t appears on out in t+1.
- First parity beat is loaded on the clock edge after the last info beat's output handshake, or after the edge that took the last info beat when the output is not stalled. Back-to-back with out_ready=1: KB info cycles, then MB parity cycles, no bubble. A codeword takes KB+MB cycles.
- The next frame's first info beat may be accepted on the edge that loads the last parity beat's handshake, i.e. while out_last is on output.
- in_ready is combinational from out_valid/out_ready/state only. No path from in_valid to in_ready.
- frame_err asserts in the cycle after the offending beat.
- Reset asserted mid-frame: outputs drop to 0 asynchronously; the partial frame is discarded.

## Test plan
- Z=4, KB=2, MB=2, SHIFT (0,0)=0, (0,1)=1, (1,0)=null, (1,1)=3. Input 4'b0001, then 4'b0010 with last, out_ready=1.
  - Out sequence: 0001, 0010, 0001 (par), 1100 (par, out_last).
  - frames_done=1; 4 consecutive out_valid cycles.
- Same config with out_ready toggled 1,0,1,0…: same 4 beats in order, each held stable while stalled; in_ready=0 while a beat is stalled.
- Two frames back-to-back; second frame 4'b1000, 4'b0000:
  - Parity 1000 then 0100.
  - No cross-frame contamination; frames_done=2.
- in_last on the first beat (ib=0): frame_err pulse, only that info beat appears on out, no parity. The next correct frame encodes correctly.
- clr asserted after the first info beat: out_valid=0 the next cycle. A following frame 0001, 0010 yields parity 0001, 1100.
- Defaults (Z=8, KB=4, MB=3, SHIFT=0), 1000 random frames: every parity block equals the XOR of the 4 info blocks. Compare against a model; zero mismatches.
